// File: rtl/serial_servo_pkg.sv
// Shared ASCII command codes and FSM state encodings for the servo command unit.
package serial_servo_pkg;

    localparam logic [6:0] CMD_GIRA     = 7'h47;
    localparam logic [6:0] CMD_PARA     = 7'h53;
    localparam logic [6:0] CMD_GIRA_MIN = 7'h67;
    localparam logic [6:0] CMD_PARA_MIN = 7'h73;
    localparam logic [6:0] CMD_DIG0     = 7'h30;
    localparam logic [6:0] CMD_DIG7     = 7'h37;
    localparam logic [6:0] ACK_ERRO     = 7'h3F;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ESPERA     = 4'd1,
        DECODIFICA = 4'd2,
        ENVIA      = 4'd3,
        AGUARDA_TX = 4'd4,
        ZERA_TX    = 4'd5
    } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Saturating modulo-M cycle counter; fim flags count == M-1 and stays there until cleared.
module contador_timeout #(
    parameter int M = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] MAX = W'(M - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && (cnt_q != MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign fim = (cnt_q == MAX);

endmodule

// File: rtl/serial_servo_cmd_uc.sv
// Servo command decoder: decodes received characters, drives gira/posicao, sends a 1-char ack.
// Optional CMD_MINUSCULA_EN accepts lower-case 'g'/'s' as aliases of 'G'/'S'.
module serial_servo_cmd_uc
    import serial_servo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 100000,
    parameter int N_BITS         = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fim_rx,
    input  logic              parity_check,
    input  logic [N_BITS-1:0] data,
    input  logic              pronto_tx,
    output logic              partida_tx,
    output logic [N_BITS-1:0] tx_data,
    output logic              zera,
    output logic              gira,
    output logic [2:0]        posicao,
    output logic              erro,
    output logic              overrun,
    output logic [3:0]        db_estado
);

    estado_t           estado_q, estado_d;
    logic [N_BITS-1:0] rx_q, rx_d;
    logic              par_q, par_d;
    logic [N_BITS-1:0] ack_q, ack_d;
    logic              gira_q, gira_d;
    logic [2:0]        posicao_q, posicao_d;
    logic              erro_q, erro_d;
    logic              overrun_q, overrun_d;
    logic              eh_gira, eh_para, eh_digito;
    logic              tmo_fim;

    contador_timeout #(.M(TIMEOUT_CICLOS)) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado_q == ENVIA),
        .enable (estado_q == AGUARDA_TX),
        .fim    (tmo_fim)
    );

    always_comb begin
        eh_gira   = (rx_q == N_BITS'(CMD_GIRA));
        eh_para   = (rx_q == N_BITS'(CMD_PARA));
`ifdef CMD_MINUSCULA_EN
        eh_gira   = eh_gira | (rx_q == N_BITS'(CMD_GIRA_MIN));
        eh_para   = eh_para | (rx_q == N_BITS'(CMD_PARA_MIN));
`endif
        eh_digito = (rx_q >= N_BITS'(CMD_DIG0)) && (rx_q <= N_BITS'(CMD_DIG7));
    end

    always_comb begin
        estado_d  = estado_q;
        rx_d      = rx_q;
        par_d     = par_q;
        ack_d     = ack_q;
        gira_d    = gira_q;
        posicao_d = posicao_q;
        erro_d    = erro_q;
        // Any character outside ESPERA is lost, including the INICIAL cycle.
        overrun_d = overrun_q | (fim_rx && (estado_q != ESPERA));
        case (estado_q)
            INICIAL: estado_d = ESPERA;
            ESPERA: begin
                if (fim_rx) begin
                    rx_d     = data;
                    par_d    = parity_check;
                    estado_d = DECODIFICA;
                end
            end
            DECODIFICA: begin
                estado_d = ENVIA;
                if (!par_q) begin
                    erro_d = 1'b1;
                    ack_d  = N_BITS'(ACK_ERRO);
                end else if (eh_gira) begin
                    gira_d = 1'b1;
                    erro_d = 1'b0;
                    ack_d  = N_BITS'(CMD_GIRA);
                end else if (eh_para) begin
                    gira_d = 1'b0;
                    erro_d = 1'b0;
                    ack_d  = N_BITS'(CMD_PARA);
                end else if (eh_digito) begin
                    posicao_d = rx_q[2:0];
                    erro_d    = 1'b0;
                    ack_d     = rx_q;
                end else begin
                    erro_d = 1'b1;
                    ack_d  = N_BITS'(ACK_ERRO);
                end
            end
            ENVIA: estado_d = AGUARDA_TX;
            AGUARDA_TX: begin
                if (pronto_tx)
                    estado_d = ESPERA;
                else if (tmo_fim)
                    estado_d = ZERA_TX;
            end
            ZERA_TX: begin
                erro_d   = 1'b1;
                estado_d = ESPERA;
            end
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            rx_q      <= '0;
            par_q     <= 1'b0;
            ack_q     <= '0;
            gira_q    <= 1'b0;
            posicao_q <= '0;
            erro_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            rx_q      <= rx_d;
            par_q     <= par_d;
            ack_q     <= ack_d;
            gira_q    <= gira_d;
            posicao_q <= posicao_d;
            erro_q    <= erro_d;
            overrun_q <= overrun_d;
        end
    end

    // INICIAL is held during reset; zera only fires once reset lets go.
    assign zera       = ((estado_q == INICIAL) && !reset) || (estado_q == ZERA_TX);
    assign partida_tx = (estado_q == ENVIA);
    assign tx_data    = ack_q;
    assign gira       = gira_q;
    assign posicao    = posicao_q;
    assign erro       = erro_q;
    assign overrun    = overrun_q;
    assign db_estado  = estado_q;

endmodule
